// File: rtl/cell_buf_loader.sv
// cell_buf_loader: streams 16-bit words into one of three cell-storage banks and serves a registered read port.
// Define CELL_BUF_CLR_EN to compile in the back-region zero sweep (CLEAR state and clr_req handling).
module cell_buf_loader #(
    parameter int FRT_CELL = 32,
    parameter int MID_CELL = 20,
    parameter int BCK_CELL = 10,
    localparam int DEPTH    = 2*FRT_CELL*MID_CELL + 2*FRT_CELL,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clr_req,
    input  logic [1:0]        cmd_bank,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    output logic              busy,
    output logic              done,
    output logic              cmd_err,
    input  logic [1:0]        rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data
);
    localparam int CLR_BASE = 2*FRT_CELL + FRT_CELL*MID_CELL;
    localparam int CLR_LEN  = FRT_CELL*MID_CELL;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(CLR_BASE);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(CLR_BASE + CLR_LEN - 1);
    localparam logic [ADDR_W-1:0] CNT_ZERO  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);

`ifdef CELL_BUF_CLR_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_CLEAR = 2'd2, ST_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_DONE = 2'd3} state_t;
    logic unused_clr_s;
    assign unused_clr_s = clr_req;
`endif

    logic [31:0] unused_bck_s;
    assign unused_bck_s = 32'(BCK_CELL);

    state_t              state_r, state_nxt_s;
    logic [ADDR_W-1:0]   cnt_r, cnt_nxt_s;
    logic [1:0]          bank_r, bank_nxt_s;
    logic                we_s;
    logic [15:0]         wdata_s;
    logic                cmd_err_s;
    logic                in_ready_r, busy_r, done_r, cmd_err_r;
    logic [15:0]         rd_data_r;
    logic                rd_ok_s;
    logic [15:0]         mem_r [0:2][0:DEPTH-1];

    // Next-state, counter, bank latch and write-port decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        bank_nxt_s  = bank_r;
        we_s        = 1'b0;
        wdata_s     = 16'h0000;
        cmd_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // start outranks clr_req; bank 3 does not exist
                if (start) begin
                    if (cmd_bank == 2'd3) begin
                        cmd_err_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_LOAD;
                        cnt_nxt_s   = CNT_ZERO;
                        bank_nxt_s  = cmd_bank;
                    end
`ifdef CELL_BUF_CLR_EN
                end else if (clr_req) begin
                    if (cmd_bank == 2'd3) begin
                        cmd_err_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_CLEAR;
                        cnt_nxt_s   = CLR_FIRST;
                        bank_nxt_s  = cmd_bank;
                    end
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    we_s    = 1'b1;
                    wdata_s = in_data;
                    if (cnt_r == LAST_ADDR) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
`ifdef CELL_BUF_CLR_EN
            ST_CLEAR: begin
                we_s = 1'b1;
                if (cnt_r == CLR_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
`endif
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control state and registered status outputs, decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            bank_r     <= 2'd0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cmd_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            bank_r     <= bank_nxt_s;
            in_ready_r <= (state_nxt_s == ST_LOAD);
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= (state_nxt_s == ST_DONE);
            cmd_err_r  <= cmd_err_s;
        end
    end

    // Storage array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we_s && !rst) begin
            mem_r[bank_r][cnt_r] <= wdata_s;
        end
    end

    assign rd_ok_s = (rd_bank != 2'd3) && (32'(rd_addr) < 32'(DEPTH));

    // Registered read port; same-cycle write to the same entry returns the old word
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= 16'h0000;
        end else if (rd_ok_s) begin
            rd_data_r <= mem_r[rd_bank][rd_addr];
        end else begin
            rd_data_r <= 16'h0000;
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign cmd_err  = cmd_err_r;
    assign rd_data  = rd_data_r;
endmodule

// File: tb/tb_cell_buf_loader.sv
// Self-checking bench for cell_buf_loader: random stream loads against an array model of the three banks.
// Clear checks follow CELL_BUF_CLR_EN; without it clr_req must have no effect.
module tb_cell_buf_loader;
    localparam int FRT = 32;
    localparam int MID = 20;
    localparam int DEPTH = 2*FRT*MID + 2*FRT;
    localparam int CLR_BASE = 2*FRT + FRT*MID;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clr_req = 1'b0;
    logic [1:0]  cmd_bank = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        busy, done, cmd_err;
    logic [1:0]  rd_bank = 2'd0;
    logic [10:0] rd_addr = 11'd0;
    logic [15:0] rd_data;

    logic [15:0] model [3][DEPTH];
    int errs = 0;
    int checks = 0;
    logic [15:0] d;

    cell_buf_loader #(.FRT_CELL(FRT), .MID_CELL(MID), .BCK_CELL(10)) dut (
        .clk(clk), .rst(rst), .start(start), .clr_req(clr_req), .cmd_bank(cmd_bank),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .done(done), .cmd_err(cmd_err),
        .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input int bank, input int addr, output logic [15:0] val);
        rd_bank = bank[1:0];
        rd_addr = addr[10:0];
        @(negedge clk);
        val = rd_data;
    endtask

    task automatic sweep(input string tag);
        int bad;
        logic [15:0] v;
        bad = 0;
        for (int b = 0; b < 3; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                rd(b, a, v);
                if (v !== model[b][a]) bad++;
            end
        end
        chk_eq(tag, bad, 0);
    endtask

    // dmode: 0 random, 1 index, 2 all-ones; vmode: 0 random, 1 toggle, 2 always
    task automatic do_load(input int bank, input int dmode, input int vmode, input bit with_clr,
                           input int abort_at, input int inject_at);
        int k, cyc, bad;
        bit v;
        logic [15:0] w;
        start = 1'b1; cmd_bank = bank[1:0]; clr_req = with_clr; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; clr_req = 1'b0;
        chk_eq("load_busy", busy, 1);
        chk_eq("load_ready", in_ready, 1);
        k = 0; cyc = 0; bad = 0;
        while (k < DEPTH && cyc < 20000) begin
            if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
            if (k == abort_at) begin
                in_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_eq("abort_done", done, 0);
                chk_eq("abort_busy", busy, 0);
                chk_eq("abort_ready", in_ready, 0);
                chk_eq("abort_flags", bad, 0);
                return;
            end
            if (k == inject_at && cyc % 2 == 0) begin
                start = 1'b1;
                cmd_bank = 2'((bank + 1) % 3);
            end
            case (vmode)
                0: v = ($urandom_range(0, 3) != 0);
                1: v = (cyc % 2 == 0);
                default: v = 1'b1;
            endcase
            case (dmode)
                0: w = 16'($urandom);
                1: w = 16'(k);
                default: w = 16'hFFFF;
            endcase
            in_valid = v;
            in_data = w;
            if (v) begin
                model[bank][k] = w;
                k++;
            end
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        chk_eq("load_count", k, DEPTH);
        chk_eq("load_flags", bad, 0);
        chk_eq("done_pulse", done, 1);
        chk_eq("done_busy", busy, 1);
        chk_eq("done_ready", in_ready, 0);
        @(negedge clk);
        chk_eq("done_drop", done, 0);
        chk_eq("idle_busy", busy, 0);
    endtask

    initial begin
        int bad, n;
        // Reset held three cycles while inputs wander
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); clr_req = 1'($urandom); cmd_bank = 2'($urandom);
            in_valid = 1'($urandom); in_data = 16'($urandom);
            rd_bank = 2'($urandom); rd_addr = 11'($urandom);
            @(negedge clk);
            if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                cmd_err !== 1'b0 || rd_data !== 16'h0000) bad++;
        end
        chk_eq("reset_outputs", bad, 0);
        rst = 1'b0; start = 1'b0; clr_req = 1'b0; in_valid = 1'b0;

        // start+clr_req together: load wins, and start right after reset release is taken
        do_load(0, 0, 0, 1'b1, -1, -1);
        do_load(1, 1, 1, 1'b0, -1, 300);
        rd(1, 1000, d);
        chk_eq("bank1_addr1000", d, 16'd1000);
        do_load(2, 0, 0, 1'b0, -1, -1);
        sweep("sweep_initial");
        rd(0, 1500, d);
        chk_eq("rd_out_of_range", d, 0);
        rd(3, 5, d);
        chk_eq("rd_bank3", d, 0);

        // Bad bank commands
        start = 1'b1; cmd_bank = 2'd3;
        @(negedge clk);
        start = 1'b0;
        chk_eq("bad_start_err", cmd_err, 1);
        chk_eq("bad_start_busy", busy, 0);
        @(negedge clk);
        chk_eq("bad_err_drop", cmd_err, 0);
        clr_req = 1'b1; cmd_bank = 2'd3;
        @(negedge clk);
        clr_req = 1'b0;
`ifdef CELL_BUF_CLR_EN
        chk_eq("bad_clr_err", cmd_err, 1);
`else
        chk_eq("bad_clr_err", cmd_err, 0);
`endif
        chk_eq("bad_clr_busy", busy, 0);
        @(negedge clk);

        // Abort a bank-2 load after 500 handshakes, then reload from address 0
        do_load(2, 0, 0, 1'b0, 500, -1);
        rd(2, 499, d);
        chk_eq("abort_addr499", d, model[2][499]);
        rd(2, 500, d);
        chk_eq("abort_addr500", d, model[2][500]);
        do_load(2, 0, 2, 1'b0, -1, -1);
        rd(2, 0, d);
        chk_eq("reload_addr0", d, model[2][0]);

`ifdef CELL_BUF_CLR_EN
        do_load(0, 2, 2, 1'b0, -1, -1);
        clr_req = 1'b1; cmd_bank = 2'd0;
        @(negedge clk);
        clr_req = 1'b0;
        n = 1; bad = 0;
        while (done !== 1'b1 && n < 2000) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge clk);
            n++;
        end
        chk_eq("clr_latency", n, 641);
        chk_eq("clr_flags", bad, 0);
        chk_eq("clr_done_busy", busy, 1);
        for (int a = CLR_BASE; a < DEPTH; a++) model[0][a] = 16'h0000;
        @(negedge clk);
        chk_eq("clr_idle", busy, 0);
        rd(0, 703, d);
        chk_eq("clr_addr703", d, 16'hFFFF);
        rd(0, 704, d);
        chk_eq("clr_addr704", d, 0);
        rd(0, 1343, d);
        chk_eq("clr_addr1343", d, 0);
`else
        clr_req = 1'b1; cmd_bank = 2'd1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clr_req = 1'b0;
            if (busy !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        chk_eq("clr_ignored", bad, 0);
`endif
        sweep("sweep_final");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cell_buf_loader.md
# cell_buf_loader

Upstream fill stage for the 3-bank cell storage array. Accepts a valid/ready stream of 16-bit words and writes them sequentially into one selected bank covering all `DEPTH = 2*FRT_CELL*MID_CELL + 2*FRT_CELL` entries. Optionally zero-sweeps the back weight region of a bank. Exposes a registered read port that the downstream compute stage consumes.

## Interface
Derived localparams: `DEPTH` as above (1344 at defaults); `CLR_BASE = 2*FRT_CELL + FRT_CELL*MID_CELL` (704); `CLR_LEN = FRT_CELL*MID_CELL` (640); `ADDR_W = $clog2(DEPTH)` (11).

Parameters:
- `FRT_CELL`, default 32: front-layer cell count.
- `MID_CELL`, default 20: mid-layer cell count.
- `BCK_CELL`, default 10: back-layer cell count. Carried for uniformity; it does not affect sizing.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins a full-bank load.
- `clr_req`, in, 1: one-cycle pulse that begins a back-region clear.
- `cmd_bank`, in, 2: target bank for `start`/`clr_req`. Valid values are 0–2.
- `in_valid`, in, 1: stream word valid.
- `in_ready`, out, 1: stream word accepted when `in_valid && in_ready`.
- `in_data`, in, 16: stream word.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse when a load or clear completes.
- `cmd_err`, out, 1: one-cycle pulse when a command is rejected.
- `rd_bank`, in, 2: read bank select.
- `rd_addr`, in, ADDR_W: read address.
- `rd_data`, out, 16: registered read data.

## Operation
- The FSM has four states: IDLE, LOAD, CLEAR, DONE.
- **Commands in IDLE:**
  - `start` latches `cmd_bank`, clears the address counter, and moves to LOAD.
  - `clr_req` latches the bank, sets the counter to `CLR_BASE`, and moves to CLEAR.
  - If both `start` and `clr_req` are high in the same cycle, `start` wins and `clr_req` is dropped.
  - A command with `cmd_bank == 3` is ignored: `cmd_err` pulses and the FSM stays in IDLE.
  - Commands arriving outside IDLE are ignored silently, with no `cmd_err`.
- **LOAD:**
  - `in_ready` = 1.
  - Each handshake writes `in_data` to `mem[bank][cnt]`, then increments `cnt`.
  - The handshake at `cnt == DEPTH-1` moves the FSM to DONE.
  - Cycles with `in_valid` low stall without writing.
- **CLEAR:**
  - Writes 16'h0000 to `mem[bank][cnt]` every cycle, with no handshake and `in_ready` = 0.
  - The write at `cnt == CLR_BASE + CLR_LEN - 1` (1343) moves the FSM to DONE.
- **DONE:** `done` = 1 for exactly one cycle, then the FSM returns to IDLE.
- **Storage:** `reg [15:0] mem[0:2][0:DEPTH-1]`. Contents are not reset. Entries outside the written range keep their prior values.
- **Read port:**
  - `rd_data <= mem[rd_bank][rd_addr]` every cycle.
  - Returns 0 if `rd_bank == 3` or `rd_addr >= DEPTH`.
  - A read and a write to the same entry in the same cycle returns the old data.
- **Counter:** `cnt` is ADDR_W bits wide and never wraps; the terminal compare precedes the increment.

## Timing
- **Reset values:** state IDLE, `cnt` 0, latched bank 0, `in_ready` 0, `busy` 0, `done` 0, `cmd_err` 0, `rd_data` 0.
- **Reset mid-operation:** asserting `rst` during LOAD or CLEAR aborts on the next edge with no `done`. Partial writes remain in the array.
- **Command latency:** `start` at edge N gives `busy` = 1 and `in_ready` = 1 from N+1.
- **Load duration:** with `in_valid` held high, a load is DEPTH cycles in LOAD, plus 1 cycle in DONE.
- **Clear duration:** CLR_LEN cycles in CLEAR, plus 1 cycle in DONE.
- **`done` timing:** `done` is asserted in the cycle after the last write. `busy` is still 1 during that DONE cycle and drops the following cycle.
- **`cmd_err` timing:** pulses the cycle after the bad command.
- **Read latency:** 1 cycle from `rd_addr`/`rd_bank` to `rd_data`.
- **Write visibility:** a word written at edge N is readable with `rd_addr` presented at N, giving data at N+1.

## Configuration
- Macro: `CELL_BUF_CLR_EN`.
- **Defined:** the CLEAR state and `clr_req` handling are compiled in as described above.
- **Undefined:**
  - The CLEAR state is absent and `clr_req` is ignored entirely: no state change, no `cmd_err`, no `done`.
  - The `clr_req` port remains on the interface, unconnected internally.

## Test plan
- **Reset defaults:** hold `rst` 3 cycles with random inputs -> all outputs 0; FSM in IDLE; `start` 1 cycle after release is accepted.
- **Full load:** load bank 1 with `in_data = index`, `in_valid` toggling every other cycle -> `done` after 1344 handshakes; `rd_bank=1`, `rd_addr=1000` returns 16'd1000 one cycle later; banks 0 and 2 unchanged.
- **Clear:** after loading bank 0 with 16'hFFFF, issue `clr_req` with `cmd_bank=0` -> `done` 641 cycles later; addr 703 reads 16'hFFFF; addrs 704 and 1343 read 0.
- **Simultaneous and bad commands:**
  - `start` + `clr_req` together -> LOAD entered, no clear.
  - `cmd_bank=3` -> `cmd_err` pulse, `busy` stays 0.
  - `start` during LOAD -> ignored.
- **Abort:** assert `rst` at handshake 500 of a bank-2 load -> no `done`; addr 499 holds its written word; a new `start` then restarts from addr 0.
- **Macro off:** without `CELL_BUF_CLR_EN`, `clr_req` -> `busy` stays 0, no `done`, memory unchanged.
